fft_radix2_iter: RTL

- Parametrised, in-place, iterative radix-2 DIT FFT/IFFT engine; successor to the fixed 8-point, real-input block.
- Accepts a parallel frame of NUM_POINTS complex fixed-point samples and runs log2(NUM_POINTS) stages through one shared butterfly, one butterfly per cycle.
- Returns the full complex spectrum on parallel output buses with a one-cycle done pulse.
- Adds run-time forward/inverse mode and optional per-stage 1/2 scaling.

---
 rtl/fft_pkg.sv | 76 +++++++
 rtl/fft_butterfly_r2.sv | 50 +++++
 rtl/fft_radix2_iter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, FSM states and elaboration-time helpers for the iterative FFT
package fft_pkg;

    localparam int MAX_POINTS = 64;
    localparam int TW_SLOT    = 32;
    localparam int CPLX_W     = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } fft_state_t;

    function automatic int fft_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int bit_reverse(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    // Packed table of N/2 twiddle entries, one TW_SLOT-wide two's-complement slot each.
    // Taylor series keeps the table computable with plain real arithmetic at elaboration.
    function automatic logic [MAX_POINTS/2*TW_SLOT-1:0] gen_twiddle(input int n, input int tw_w,
                                                                   input bit sine);
        logic [MAX_POINTS/2*TW_SLOT-1:0] tab;
        real x;
        real term;
        real sum;
        real scaled;
        int  q;
        int  max_code;
        tab      = '0;
        max_code = (1 << (tw_w - 1)) - 1;
        for (int m = 0; m < n / 2; m++) begin
            x = 2.0 * 3.14159265358979323846 * real'(m) / real'(n);
            if (sine) begin
                term = x;
                sum  = x;
                for (int k = 1; k <= 20; k++) begin
                    term = -term * x * x / real'((2 * k) * (2 * k + 1));
                    sum  = sum + term;
                end
            end else begin
                term = 1.0;
                sum  = 1.0;
                for (int k = 1; k <= 20; k++) begin
                    term = -term * x * x / real'((2 * k - 1) * (2 * k));
                    sum  = sum + term;
                end
            end
            scaled = sum * real'(1 << (tw_w - 2));
            q = (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
            if (q > max_code) q = max_code;
            if (q < -max_code - 1) q = -max_code - 1;
            tab[m*TW_SLOT +: TW_SLOT] = q;
        end
        return tab;
    endfunction

endpackage

// File: rtl/fft_butterfly_r2.sv
// rtl/fft_butterfly_r2.sv - combinational radix-2 DIT butterfly with rounding, scaling and saturation
module fft_butterfly_r2 #(
    parameter int SIZE_DATA = 16,
    parameter int SIZE_TW   = 16,
    parameter int SCALE_EN  = 1
) (
    input  logic signed [SIZE_DATA-1:0] a_re,
    input  logic signed [SIZE_DATA-1:0] a_im,
    input  logic signed [SIZE_DATA-1:0] b_re,
    input  logic signed [SIZE_DATA-1:0] b_im,
    input  logic signed [SIZE_TW-1:0]   w_re,
    input  logic signed [SIZE_TW-1:0]   w_im,
    output logic signed [SIZE_DATA-1:0] y_a_re,
    output logic signed [SIZE_DATA-1:0] y_a_im,
    output logic signed [SIZE_DATA-1:0] y_b_re,
    output logic signed [SIZE_DATA-1:0] y_b_im
);

    localparam int PW = SIZE_DATA + SIZE_TW + 1;
    localparam int SW = SIZE_DATA + 2;
    localparam logic signed [PW-1:0] RND  = PW'(1) << (SIZE_TW - 3);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (SIZE_DATA - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [PW-1:0] m_re, m_im, r_re, r_im;
    logic signed [SW-1:0] p_re, p_im;

    function automatic logic signed [SIZE_DATA-1:0] finish(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] t;
        t = (SCALE_EN != 0) ? (v >>> 1) : v;
        if (t > MAXV) t = MAXV;
        if (t < MINV) t = MINV;
        return t[SIZE_DATA-1:0];
    endfunction

    always_comb begin
        m_re = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im);
        m_im = PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re);
        r_re = (m_re + RND) >>> (SIZE_TW - 2);
        r_im = (m_im + RND) >>> (SIZE_TW - 2);
        // |w*b| stays below 2^(SIZE_DATA+1), so the low SW bits hold the product exactly
        p_re = r_re[SW-1:0];
        p_im = r_im[SW-1:0];
        y_a_re = finish(SW'(a_re) + p_re);
        y_a_im = finish(SW'(a_im) + p_im);
        y_b_re = finish(SW'(a_re) - p_re);
        y_b_im = finish(SW'(a_im) - p_im);
    end

endmodule

// File: rtl/fft_radix2_iter.sv
// rtl/fft_radix2_iter.sv - in-place iterative radix-2 DIT FFT/IFFT engine, one butterfly per cycle
module fft_radix2_iter
    import fft_pkg::*;
#(
    parameter int NUM_POINTS = 8,
    parameter int SIZE_DATA  = 16,
    parameter int SIZE_TW    = 16,
    parameter int SCALE_EN   = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_inverse,
    input  logic [NUM_POINTS*SIZE_DATA-1:0] i_data_re,
    input  logic [NUM_POINTS*SIZE_DATA-1:0] i_data_im,
    output logic [NUM_POINTS*SIZE_DATA-1:0] o_data_re,
    output logic [NUM_POINTS*SIZE_DATA-1:0] o_data_im,
    output logic                            o_ready,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int S      = fft_log2(NUM_POINTS);
    localparam int AW     = S;
    localparam int HALF_N = NUM_POINTS / 2;
    localparam logic [MAX_POINTS/2*TW_SLOT-1:0] TW_COS = gen_twiddle(NUM_POINTS, SIZE_TW, 1'b0);
    localparam logic [MAX_POINTS/2*TW_SLOT-1:0] TW_SIN = gen_twiddle(NUM_POINTS, SIZE_TW, 1'b1);

    fft_state_t state, state_nxt;
    logic [2:0]    stage;
    logic [AW-1:0] bfly;
    logic          inverse_q;

    logic signed [SIZE_DATA-1:0] mem_re [NUM_POINTS];
    logic signed [SIZE_DATA-1:0] mem_im [NUM_POINTS];

    logic [AW-1:0] half, k_idx, addr_a, addr_b, tw_idx;
    logic signed [SIZE_TW-1:0] w_re, w_im, sin_v;
    logic signed [SIZE_DATA-1:0] y_a_re, y_a_im, y_b_re, y_b_im;
    logic last_bfly;

    always_comb begin
        half   = AW'(1) << stage;
        k_idx  = bfly & (half - AW'(1));
        addr_a = (((bfly >> stage) << stage) << 1) | k_idx;
        addr_b = addr_a | half;
        tw_idx = k_idx << (3'(S - 1) - stage);
        w_re   = TW_COS[tw_idx*TW_SLOT +: SIZE_TW];
        sin_v  = TW_SIN[tw_idx*TW_SLOT +: SIZE_TW];
        // Forward uses cos - j*sin; inverse conjugates the twiddle
        w_im   = inverse_q ? sin_v : -sin_v;
        last_bfly = (stage == 3'(S - 1)) && (bfly == AW'(HALF_N - 1));
    end

    fft_butterfly_r2 #(
        .SIZE_DATA(SIZE_DATA),
        .SIZE_TW  (SIZE_TW),
        .SCALE_EN (SCALE_EN)
    ) u_butterfly (
        .a_re  (mem_re[addr_a]),
        .a_im  (mem_im[addr_a]),
        .b_re  (mem_re[addr_b]),
        .b_im  (mem_im[addr_b]),
        .w_re  (w_re),
        .w_im  (w_im),
        .y_a_re(y_a_re),
        .y_a_im(y_a_im),
        .y_b_re(y_b_re),
        .y_b_im(y_b_im)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_busy    = 1'b0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                o_busy = 1'b1;
                if (last_bfly) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stage     <= '0;
            bfly      <= '0;
            inverse_q <= 1'b0;
            o_done    <= 1'b0;
            o_data_re <= '0;
            o_data_im <= '0;
            for (int i = 0; i < NUM_POINTS; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        for (int i = 0; i < NUM_POINTS; i++) begin
                            mem_re[AW'(bit_reverse(i, S))] <= i_data_re[i*SIZE_DATA +: SIZE_DATA];
                            mem_im[AW'(bit_reverse(i, S))] <= i_data_im[i*SIZE_DATA +: SIZE_DATA];
                        end
                        inverse_q <= i_inverse;
                        stage     <= '0;
                        bfly      <= '0;
                    end
                end
                ST_COMPUTE: begin
                    mem_re[addr_a] <= y_a_re;
                    mem_im[addr_a] <= y_a_im;
                    mem_re[addr_b] <= y_b_re;
                    mem_im[addr_b] <= y_b_im;
                    if (bfly == AW'(HALF_N - 1)) begin
                        bfly  <= '0;
                        stage <= stage + 3'd1;
                    end else begin
                        bfly <= bfly + AW'(1);
                    end
                end
                ST_DONE: begin
                    for (int i = 0; i < NUM_POINTS; i++) begin
                        o_data_re[i*SIZE_DATA +: SIZE_DATA] <= mem_re[AW'(i)];
                        o_data_im[i*SIZE_DATA +: SIZE_DATA] <= mem_im[AW'(i)];
                    end
                    o_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
